nanorv32_tcm_xbar: RTL
======================

Name: nanorv32_tcm_xbar

Overview:
Parametrised M-master x S-target crossbar replacing the fixed 2x3 code/data TCM switch in nanorv32 systems.
- Each master (CPU code port, CPU data port, DMA, debug) has its request decoded on address bits [31:28] to one target (code TCM, data TCM, peripheral bus, extra banks).
- Conflicts are resolved per target by a round-robin arbiter.
- Read data is routed back with registered steering, one cycle after acceptance.
- Sits between the core/DMA ports and nanorv32_tcm_ctrl instances and the peripheral bus.

Parameters:
- NUM_M, 2, number of masters; index 0 = CPU code port, 1 = CPU data port.
- NUM_S, 3, number of targets.
- ADDR_WIDTH, 12, target-side address width; target address = master addr[ADDR_WIDTH-1:0].
- DATA_WIDTH, 32, data width.
- S_REGION, {4'hF,4'h2,4'h0}, NUM_S*4 bits; nibble s = addr[31:28] value selecting target s.
- DEFAULT_S, 2, target for unmatched regions when NANORV32_XBAR_DECERR_EN is undefined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m_req  in  NUM_M  per-master request.
- m_addr  in  NUM_M*32  byte addresses.
- m_wdata  in  NUM_M*DATA_WIDTH  write data.
- m_bytesel  in  NUM_M*4  byte enables; all-zero = read.
- m_rdata  out  NUM_M*DATA_WIDTH  read data, valid when m_ready_r.
- m_early_ready  out  NUM_M  access accepted this cycle.
- m_ready_r  out  NUM_M  registered m_early_ready.
- m_err_r  out  NUM_M  decode error flag (feature only; else tied 0).
- s_en  out  NUM_S  target enable.
- s_addr  out  NUM_S*ADDR_WIDTH  target address.
- s_din  out  NUM_S*DATA_WIDTH  target write data.
- s_bytesel  out  NUM_S*4  target byte enables.
- s_dout  in  NUM_S*DATA_WIDTH  target read data, valid the cycle after acceptance.
- s_ready_nxt  in  NUM_S  target accepts the access this cycle.

Behaviour:
- Decode (combinational): tgt[m] = lowest s whose S_REGION nibble equals m_addr[m][31:28]; no match -> DEFAULT_S (or error, see feature). Code/data port masters are not special-cased.
- Arbitration per target s, combinational: candidates are masters with m_req and tgt==s. Grant goes to the first candidate scanning from ptr[s]+1 modulo NUM_M.
- ptr[s] is a register, reset to NUM_M-1, so master 0 has priority first after reset.
- ptr[s] is updated to the granted index only when s_en[s] && s_ready_nxt[s]. A stalled grant holds priority.
- Granted target: s_en=1; s_addr/s_din/s_bytesel taken from the winner.
- Idle target: s_en=0; addr, din and bytesel driven 0.
- m_early_ready[m] = granted && s_ready_nxt[tgt]. Losing or unrequesting masters get 0.
- A loser must hold req/addr/wdata stable until accepted.
- Steering registers (per master): on m_early_ready, rsel_r[m] <= tgt and rvld_r[m] <= 1; otherwise rvld_r <= 0.
- m_rdata[m] = rvld_r ? s_dout[rsel_r] : 0.
- m_ready_r <= m_early_ready. Read latency is 1 cycle after acceptance; throughput is 1 access/cycle/target.
- Simultaneous: different targets proceed in parallel, with no penalty for crossed accesses (code->data TCM while data->code TCM). Same target: one winner per cycle.
- NUM_M==1: arbiter degenerates to pass-through; ptr is unused.
- Reset (including mid-transfer): ptr=NUM_M-1, rsel_r=0, rvld_r=0, m_ready_r=0, m_err_r=0. Combinational outputs follow inputs immediately. An in-flight read is dropped; no m_ready_r pulse after reset release.

Optional Feature:
- Macro: NANORV32_XBAR_DECERR_EN.
- Defined:
  - An unmatched region drives no target.
  - m_early_ready=1 in the same cycle, without arbitration.
  - Next cycle: m_ready_r=1, m_err_r=1, m_rdata=32'hDEADBEEF.
  - Writes to an unmatched region are discarded.
- Undefined: unmatched accesses route to DEFAULT_S; m_err_r is constant 0.

Decomposition:
- nanorv32_xbar_parameters.v (included like nanorv32_parameters.v):
  - region nibble constants CODE=4'h0, DATA=4'h2, PERIPH=4'hF;
  - DECERR_RDATA=32'hDEADBEEF;
  - a clog2 function for index widths.
- Sub-module nanorv32_rr_arbiter (params NUM_M):
  - inputs req vector, advance;
  - output one-hot grant;
  - owns ptr;
  - instantiated NUM_S times in a generate loop.

Test Plan:
- Default params; m0 fetches 0x0000_0010, m1 loads 0x2000_0008, both ready_nxt=1. Expected: both early_ready same cycle; next cycle m_rdata0 = code dout, m_rdata1 = data dout, both ready_r=1.
- Crossed: m0 fetches 0x2000_0100, m1 writes 0x0000_0040 with bytesel 4'hF, wdata 0x12345678. Expected: s_addr[1]=0x100, s_din[0]=0x12345678, s_bytesel[0]=4'hF, no stall.
- Conflict: both masters request 0x2000_0000 for 4 consecutive cycles, target always ready. Expected: grants m0,m1,m0,m1 after reset.
- Conflict with s_ready_nxt[1]=0 for 3 cycles. Expected: m0 stays granted and ptr unchanged; m1 gets the next grant after m0 is accepted.
- m1 loads 0x5000_0000. Without macro: s_en[2]=1, s_addr[2]=0x000. With NANORV32_XBAR_DECERR_EN: no s_en; next cycle m_err_r[1]=1, m_rdata1=0xDEADBEEF.
- Assert rst_n low in the cycle after early_ready of a read. Expected: m_ready_r=0 and m_rdata=0 during reset, ptr back to NUM_M-1, no stray ready after release.

Source files
------------

// File: rtl/nanorv32_tcm_xbar_pkg.sv
// Shared constants and helpers for the nanorv32 TCM crossbar slice.
package nanorv32_tcm_xbar_pkg;

  localparam logic [3:0]  REGION_CODE   = 4'h0;
  localparam logic [3:0]  REGION_DATA   = 4'h2;
  localparam logic [3:0]  REGION_PERIPH = 4'hF;
  localparam logic [31:0] DECERR_RDATA  = 32'hDEADBEEF;

  // Index width for n items; never below 1 so single-entry vectors stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nanorv32_tcm_xbar_rr_arbiter.sv
// Per-target round-robin arbiter: one-hot grant, priority pointer advances on acceptance.
module nanorv32_rr_arbiter
  import nanorv32_tcm_xbar_pkg::*;
#(
  parameter int unsigned NUM_M = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] req_i,
  input  logic             advance_i,
  output logic [NUM_M-1:0] grant_o
);

  if (NUM_M == 1) begin : g_pass
    assign grant_o = req_i;
  end else begin : g_rr
    localparam int unsigned PW = clog2(NUM_M);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= NUM_M; k++) begin
        idx = PW'((32'(ptr_q) + k) % NUM_M);
        if (!found && req_i[idx]) begin
          grant_o[idx] = 1'b1;
          found        = 1'b1;
          if (advance_i) ptr_d = idx;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= PW'(NUM_M - 1);
      else        ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nanorv32_tcm_xbar.sv
// M-master x S-target TCM crossbar with round-robin arbitration and registered read steering.
// NANORV32_XBAR_DECERR_EN: unmatched regions complete immediately with a decode error.
module nanorv32_tcm_xbar
  import nanorv32_tcm_xbar_pkg::*;
#(
  parameter int unsigned         NUM_M      = 2,
  parameter int unsigned         NUM_S      = 3,
  parameter int unsigned         ADDR_WIDTH = 12,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter logic [NUM_S*4-1:0]  S_REGION   = {REGION_PERIPH, REGION_DATA, REGION_CODE},
  parameter int unsigned         DEFAULT_S  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_M-1:0]              m_req,
  input  logic [NUM_M*32-1:0]           m_addr,
  input  logic [NUM_M*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_M*4-1:0]            m_bytesel,
  output logic [NUM_M*DATA_WIDTH-1:0]   m_rdata,
  output logic [NUM_M-1:0]              m_early_ready,
  output logic [NUM_M-1:0]              m_ready_r,
  output logic [NUM_M-1:0]              m_err_r,
  output logic [NUM_S-1:0]              s_en,
  output logic [NUM_S*ADDR_WIDTH-1:0]   s_addr,
  output logic [NUM_S*DATA_WIDTH-1:0]   s_din,
  output logic [NUM_S*4-1:0]            s_bytesel,
  input  logic [NUM_S*DATA_WIDTH-1:0]   s_dout,
  input  logic [NUM_S-1:0]              s_ready_nxt
);

  localparam int unsigned SW = clog2(NUM_S);

  logic [SW-1:0]    tgt     [NUM_M];
  logic [NUM_M-1:0] hit;
  logic [NUM_M-1:0] sreq    [NUM_S];
  logic [NUM_M-1:0] grant   [NUM_S];
  logic [NUM_S-1:0] adv;
  logic [SW-1:0]    rsel_q  [NUM_M];
  logic [SW-1:0]    rsel_d  [NUM_M];
  logic [NUM_M-1:0] rvld_q, rvld_d;
  logic             unused_addr;

  assign unused_addr = ^m_addr;

  // Lowest matching region wins; unmatched goes to DEFAULT_S unless decode errors are enabled.
  always_comb begin
    for (int unsigned m = 0; m < NUM_M; m++) begin
      logic matched;
      matched = 1'b0;
      tgt[m]  = SW'(DEFAULT_S);
      for (int unsigned s = 0; s < NUM_S; s++) begin
        if (!matched && m_addr[m*32+28 +: 4] == S_REGION[s*4 +: 4]) begin
          tgt[m]  = SW'(s);
          matched = 1'b1;
        end
      end
`ifdef NANORV32_XBAR_DECERR_EN
      hit[m] = matched;
`else
      hit[m] = 1'b1;
`endif
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NUM_S; s++) begin
      sreq[s] = '0;
      for (int unsigned m = 0; m < NUM_M; m++)
        sreq[s][m] = m_req[m] && hit[m] && (tgt[m] == SW'(s));
    end
  end

  for (genvar s = 0; s < NUM_S; s++) begin : g_arb
    assign adv[s] = s_en[s] & s_ready_nxt[s];
    nanorv32_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (sreq[s]),
      .advance_i (adv[s]),
      .grant_o   (grant[s])
    );
  end

  always_comb begin
    s_en      = '0;
    s_addr    = '0;
    s_din     = '0;
    s_bytesel = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      for (int unsigned m = 0; m < NUM_M; m++) begin
        if (grant[s][m]) begin
          s_en[s]                             = 1'b1;
          s_addr[s*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr[m*32 +: ADDR_WIDTH];
          s_din[s*DATA_WIDTH +: DATA_WIDTH]   = m_wdata[m*DATA_WIDTH +: DATA_WIDTH];
          s_bytesel[s*4 +: 4]                 = m_bytesel[m*4 +: 4];
        end
      end
    end
  end

  always_comb begin
    m_early_ready = '0;
    for (int unsigned m = 0; m < NUM_M; m++) begin
      if (m_req[m]) begin
        if (!hit[m]) m_early_ready[m] = 1'b1;
        else         m_early_ready[m] = grant[tgt[m]][m] && s_ready_nxt[tgt[m]];
      end
    end
  end

  always_comb begin
    rvld_d = m_early_ready;
    for (int unsigned m = 0; m < NUM_M; m++)
      rsel_d[m] = m_early_ready[m] ? tgt[m] : rsel_q[m];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvld_q <= '0;
      for (int unsigned m = 0; m < NUM_M; m++) rsel_q[m] <= '0;
    end else begin
      rvld_q <= rvld_d;
      for (int unsigned m = 0; m < NUM_M; m++) rsel_q[m] <= rsel_d[m];
    end
  end

  assign m_ready_r = rvld_q;

`ifdef NANORV32_XBAR_DECERR_EN
  logic [NUM_M-1:0] err_q, err_d;

  assign err_d = m_early_ready & ~hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign m_err_r = err_q;

  always_comb begin
    for (int unsigned m = 0; m < NUM_M; m++) begin
      m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = '0;
      if (rvld_q[m]) begin
        if (err_q[m]) m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(DECERR_RDATA);
        else          m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = s_dout[int'(rsel_q[m])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
`else
  assign m_err_r = '0;

  always_comb begin
    for (int unsigned m = 0; m < NUM_M; m++) begin
      m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = '0;
      if (rvld_q[m])
        m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = s_dout[int'(rsel_q[m])*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

endmodule
